// File: rtl/screen_mode_controller_if.sv
// Renderer/game-core/VGA side signals of the screen sequencer.
// The controller takes the master modport; the renderers, game core and VGA stage take the slave modport.
interface screen_mode_controller_if;
    logic        frame_start;
    logic        game_lost;
    logic        game_won;
    logic        active_pixels;
    logic [23:0] start_color;
    logic [23:0] game_color;
    logic [23:0] end_color;
    logic [23:0] color_out;
    logic [1:0]  mode;
    logic        game_reset;
    logic        game_enable;
    logic        blink;

    modport master (
        input  frame_start, game_lost, game_won, active_pixels,
        input  start_color, game_color, end_color,
        output color_out, mode, game_reset, game_enable, blink
    );

    modport slave (
        output frame_start, game_lost, game_won, active_pixels,
        output start_color, game_color, end_color,
        input  color_out, mode, game_reset, game_enable, blink
    );
endinterface

// File: rtl/screen_mode_controller.sv
// Minesweeper game-flow sequencer: START -> PLAY -> LOST/WON -> START.
// Selects the renderer colour, gates the game core and generates a frame-rate blink.
module screen_mode_controller #(
    parameter int unsigned BLINK_FRAMES    = 30,
    parameter int unsigned END_HOLD_FRAMES = 120
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_btn_n,
    screen_mode_controller_if.master  bus
);
    localparam int unsigned BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int unsigned HOLD_W  = (END_HOLD_FRAMES > 0) ? $clog2(END_HOLD_FRAMES + 1) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);
    localparam logic [HOLD_W-1:0]  HOLD_MAX   = HOLD_W'(END_HOLD_FRAMES);

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_PLAY  = 2'd1,
        ST_LOST  = 2'd2,
        ST_WON   = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic               sync1_q, sync1_d;
    logic               sync2_q, sync2_d;
    logic               btn_prev_q, btn_prev_d;
    logic               start_pulse_q, start_pulse_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_q, blink_d;
    logic [1:0]         mode_q, mode_d;
    logic               game_reset_q, game_reset_d;
    logic               game_enable_q, game_enable_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_START;
            sync1_q       <= 1'b1;
            sync2_q       <= 1'b1;
            btn_prev_q    <= 1'b1;
            start_pulse_q <= 1'b0;
            hold_cnt_q    <= '0;
            blink_cnt_q   <= '0;
            blink_q       <= 1'b1;
            mode_q        <= 2'd0;
            game_reset_q  <= 1'b0;
            game_enable_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            btn_prev_q    <= btn_prev_d;
            start_pulse_q <= start_pulse_d;
            hold_cnt_q    <= hold_cnt_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_q       <= blink_d;
            mode_q        <= mode_d;
            game_reset_q  <= game_reset_d;
            game_enable_q <= game_enable_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        blink_cnt_d  = blink_cnt_q;
        blink_d      = blink_q;
        mode_d       = mode_q;
        game_reset_d = 1'b0;

        // Two-flop synchroniser, then a registered falling-edge detect (3 clk pin-to-pulse).
        sync1_d       = start_btn_n;
        sync2_d       = sync1_q;
        btn_prev_d    = sync2_q;
        start_pulse_d = btn_prev_q & ~sync2_q;

        case (state_q)
            ST_START: begin
                if (start_pulse_q) begin
                    state_d      = ST_PLAY;
                    game_reset_d = 1'b1;
                end
            end
            ST_PLAY: begin
                if (bus.game_lost) begin
                    state_d    = ST_LOST;
                    hold_cnt_d = '0;
                end else if (bus.game_won) begin
                    state_d    = ST_WON;
                    hold_cnt_d = '0;
                end
            end
            ST_LOST, ST_WON: begin
                // Presses before the hold-off expires are simply dropped.
                if (start_pulse_q && (hold_cnt_q == HOLD_MAX)) begin
                    state_d = ST_START;
                end else if (bus.frame_start && (hold_cnt_q != HOLD_MAX)) begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
        endcase

        game_enable_d = (state_d == ST_PLAY);

        // Mode only follows state at frame boundaries, using the pre-edge state.
        if (bus.frame_start) begin
            mode_d = 2'(state_q);
        end

        if ((state_d == ST_START) && (state_q != ST_START)) begin
            blink_cnt_d = '0;
            blink_d     = 1'b1;
        end else if (bus.frame_start) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                blink_d     = ~blink_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BLINK_W'(1);
            end
        end
    end

    always_comb begin
        bus.color_out = 24'h000000;
        if (bus.active_pixels) begin
            case (mode_q)
                2'd0:    bus.color_out = bus.start_color;
                2'd1:    bus.color_out = bus.game_color;
                default: bus.color_out = bus.end_color;
            endcase
        end
    end

    assign bus.mode        = mode_q;
    assign bus.game_reset  = game_reset_q;
    assign bus.game_enable = game_enable_q;
    assign bus.blink       = blink_q;
endmodule

// File: tb/tb_screen_mode_controller.sv
// Scoreboard bench for screen_mode_controller: a rule-level game-flow model predicts every cycle's
// outputs into a queue, and an independent monitor compares them against the DUT after each edge.
module tb_screen_mode_controller;
    localparam int BF = 2;
    localparam int EH = 12;

    logic clk = 1'b0;
    logic rst;
    logic btn_n;

    screen_mode_controller_if sif ();

    screen_mode_controller #(
        .BLINK_FRAMES   (BF),
        .END_HOLD_FRAMES(EH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_btn_n(btn_n),
        .bus        (sif)
    );

    always #5 clk = ~clk;

    typedef struct {
        int mode;
        int gr;
        int en;
        int blink;
        int color;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   running  = 1'b1;

    // Model: screen phase 0..3 (START/PLAY/LOST/WON), frames seen since the last return to START,
    // frames spent in the end screen, and the last four sampled button levels.
    int m_phase;
    int m_mode;
    int m_gr;
    int m_end_frames;
    int m_frames;
    bit hist[$];
    int frame_cd = 2;

    task automatic check(input string name, input int got, input int want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    endtask

    function automatic void model_reset();
        m_phase      = 0;
        m_mode       = 0;
        m_gr         = 0;
        m_end_frames = 0;
        m_frames     = 0;
        hist.delete();
        repeat (4) hist.push_back(1'b1);
    endfunction

    // Predicts the outputs seen after the next rising edge, given the inputs now on the pins.
    function automatic exp_t model_step();
        exp_t e;
        bit   pulse;
        int   pre;
        if (rst) begin
            model_reset();
        end else begin
            // A press is acted on four edges after the pin is first sampled low.
            pulse = hist[0] && !hist[1];
            void'(hist.pop_front());
            hist.push_back(btn_n);
            pre  = m_phase;
            m_gr = 0;
            if (pre == 0) begin
                if (pulse) begin
                    m_phase = 1;
                    m_gr    = 1;
                end
            end else if (pre == 1) begin
                if (sif.game_lost) begin
                    m_phase = 2; m_end_frames = 0;
                end else if (sif.game_won) begin
                    m_phase = 3; m_end_frames = 0;
                end
            end else begin
                if (pulse && m_end_frames >= EH) m_phase = 0;
                else if (sif.frame_start) m_end_frames++;
            end
            if (sif.frame_start) m_mode = pre;
            if (m_phase == 0 && pre != 0) m_frames = 0;
            else if (sif.frame_start) m_frames++;
        end
        e.mode  = m_mode;
        e.gr    = m_gr;
        e.en    = (m_phase == 1) ? 1 : 0;
        e.blink = (((m_frames / BF) % 2) == 0) ? 1 : 0;
        if (!sif.active_pixels) e.color = 0;
        else if (m_mode == 0)   e.color = int'(sif.start_color);
        else if (m_mode == 1)   e.color = int'(sif.game_color);
        else                    e.color = int'(sif.end_color);
        return e;
    endfunction

    // Finalise this cycle's inputs, record the prediction, then move to the next falling edge.
    task automatic cycle();
        sif.start_color   = 24'($urandom);
        sif.game_color    = 24'($urandom);
        sif.end_color     = 24'($urandom);
        sif.active_pixels = ($urandom_range(3) != 0);
        if (frame_cd == 0) begin
            sif.frame_start = 1'b1;
            frame_cd = $urandom_range(3, 8);
        end else begin
            sif.frame_start = 1'b0;
            frame_cd--;
        end
        exp_q.push_back(model_step());
        @(negedge clk);
    endtask

    task automatic press(input int hold, input int after);
        btn_n = 1'b0;
        repeat (hold) cycle();
        btn_n = 1'b1;
        repeat (after) cycle();
    endtask

    // Monitor: compares one prediction per rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("mode",        int'(sif.mode),        e.mode);
                check("game_reset",  int'(sif.game_reset),  e.gr);
                check("game_enable", int'(sif.game_enable), e.en);
                check("blink",       int'(sif.blink),       e.blink);
                check("color_out",   int'(sif.color_out),   e.color);
            end else if (running) begin
                n_checks++;
                $display("FAIL scoreboard_empty: no prediction queued at %0t", $time);
            end
        end
    end

    initial begin
        rst             = 1'b1;
        btn_n           = 1'b1;
        sif.game_lost   = 1'b0;
        sif.game_won    = 1'b0;
        sif.frame_start = 1'b0;
        model_reset();
        repeat (3) cycle();
        rst = 1'b0;
        repeat (10) cycle();

        // Long press starts one game only.
        press(100, 10);

        // Simultaneous loss and win: loss wins.
        sif.game_lost = 1'b1;
        sif.game_won  = 1'b1;
        cycle();
        sif.game_lost = 1'b0;
        sif.game_won  = 1'b0;

        // Early press during the hold-off is dropped; a late one returns to START.
        repeat (30) cycle();
        press(5, 120);
        press(5, 10);

        // New game, then reset in the middle of play.
        press(5, 20);
        rst = 1'b1;
        #1;
        check("async_rst_game_enable", int'(sif.game_enable), 0);
        check("async_rst_blink",       int'(sif.blink),       1);
        check("async_rst_mode",        int'(sif.mode),        0);
        check("async_rst_game_reset",  int'(sif.game_reset),  0);
        cycle();
        cycle();
        rst = 1'b0;
        repeat (20) cycle();

        // Won path with blink running through START and PLAY.
        press(4, 15);
        sif.game_won = 1'b1;
        cycle();
        sif.game_won = 1'b0;
        repeat (150) cycle();
        press(3, 30);

        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(15) == 0) btn_n = ~btn_n;
            sif.game_lost = ($urandom_range(60) == 0);
            sif.game_won  = ($urandom_range(60) == 0);
            rst           = ($urandom_range(2000) == 0);
            cycle();
        end
        rst = 1'b0;
        running = 1'b0;
        repeat (2) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
